// File: rtl/axis_skid_chain.sv
// -----------------------------------------------------------------------------
// axis_skid_chain
//
// Chain of NUM_SLICES fully-registered skid-buffer slices for a
// valid/ready/data/last stream. Placed on long host<->kernel stream paths so
// that neither the forward (valid/data/last) nor the backward (ready) path
// crosses more than one slice combinationally.
//
// Parameters
//   DATA_W      data bus width in bits (>= 1)
//   NUM_SLICES  number of register slices (0..16); 0 = combinational wire-through
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous clear of every buffered beat (datapath effect
//                   identical to rst)
//   us_valid   in   upstream beat valid
//   us_data    in   upstream beat data [DATA_W]
//   us_last    in   upstream end-of-packet marker
//   us_ready   out  chain accepts the upstream beat (straight from a flop)
//   ds_valid   out  downstream beat valid (straight from a flop)
//   ds_data    out  downstream beat data [DATA_W]
//   ds_last    out  downstream end-of-packet marker
//   ds_ready   in   downstream accepts the beat
//   occ        out  only with AXIS_SKID_CHAIN_OCC_EN defined: number of beats
//                   currently held, width $clog2(2*NUM_SLICES+1) (1 bit,
//                   tied to 0, when NUM_SLICES = 0)
//
// Optional feature macro: AXIS_SKID_CHAIN_OCC_EN (occupancy counter + port).
//
// Handshake: a beat moves across a port in every cycle where valid and ready
// are both 1 at the rising edge. A producer that raises valid keeps valid,
// data and last unchanged until that transfer happens; ready may change
// freely. Beats leave in arrival order, never duplicated or dropped, except
// that rst/flush discard everything held (including a beat offered in the
// same cycle).
//
// Capacity is 2 beats per slice: a main register that drives the slice
// output and a skid register that catches the one beat already in flight
// when the downstream side stalls. Slice input ready is ~skid_valid, a flop,
// so the ready path is broken at every slice.
// -----------------------------------------------------------------------------
module axis_skid_chain #(
    parameter int DATA_W     = 512,
    parameter int NUM_SLICES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              us_valid,
    input  logic [DATA_W-1:0] us_data,
    input  logic              us_last,
    output logic              us_ready,
    output logic              ds_valid,
    output logic [DATA_W-1:0] ds_data,
    output logic              ds_last,
    input  logic              ds_ready
`ifdef AXIS_SKID_CHAIN_OCC_EN
   ,output logic [((NUM_SLICES == 0) ? 1 : $clog2(2*NUM_SLICES + 1))-1:0] occ
`endif
);

    generate
        if (NUM_SLICES == 0) begin : g_bypass
            // No storage at all: the chain degenerates to wires in both
            // directions, and clk/rst/flush have nothing to act on.
            assign ds_valid = us_valid;
            assign ds_data  = us_data;
            assign ds_last  = us_last;
            assign us_ready = ds_ready;

            logic unused_bypass;
            assign unused_bypass = ^{clk, rst, flush};
        end else begin : g_chain
            // Stage k is the interface between slice k-1 and slice k.
            // Stage 0 is the upstream port, stage NUM_SLICES the downstream
            // port. Each slice drives valid/data/last of stage i+1 and
            // ready of stage i.
            logic              stg_valid [NUM_SLICES+1];
            logic [DATA_W-1:0] stg_data  [NUM_SLICES+1];
            logic              stg_last  [NUM_SLICES+1];
            logic              stg_ready [NUM_SLICES+1];

            assign stg_valid[0]          = us_valid;
            assign stg_data[0]           = us_data;
            assign stg_last[0]           = us_last;
            assign us_ready              = stg_ready[0];

            assign ds_valid              = stg_valid[NUM_SLICES];
            assign ds_data               = stg_data[NUM_SLICES];
            assign ds_last               = stg_last[NUM_SLICES];
            assign stg_ready[NUM_SLICES] = ds_ready;

            for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
                // Main register: drives the slice output.
                logic              m_vld;
                logic [DATA_W-1:0] m_dat;
                logic              m_lst;
                // Skid register: holds the beat accepted while main stalled.
                logic              k_vld;
                logic [DATA_W-1:0] k_dat;
                logic              k_lst;

                logic              in_valid;
                logic [DATA_W-1:0] in_data;
                logic              in_last;
                logic              out_ready;
                logic              in_hs;
                logic              out_hs;

                // Register load selects; at most one is set per cycle.
                logic              main_from_skid;
                logic              main_from_in;
                logic              skid_from_in;

                assign in_valid         = stg_valid[i];
                assign in_data          = stg_data[i];
                assign in_last          = stg_last[i];
                assign out_ready        = stg_ready[i+1];

                assign stg_valid[i+1]   = m_vld;
                assign stg_data[i+1]    = m_dat;
                assign stg_last[i+1]    = m_lst;
                assign stg_ready[i]     = ~k_vld;

                assign in_hs            = in_valid & ~k_vld;
                assign out_hs           = m_vld & out_ready;

                always_comb begin
                    main_from_skid = 1'b0;
                    main_from_in   = 1'b0;
                    skid_from_in   = 1'b0;
                    if (k_vld && out_hs) begin
                        // Skid full means input ready was low, so no
                        // input beat can arrive in this cycle.
                        main_from_skid = 1'b1;
                    end else if (in_hs && (!m_vld || out_hs)) begin
                        main_from_in = 1'b1;
                    end else if (in_hs && m_vld && !out_ready) begin
                        skid_from_in = 1'b1;
                    end
                end

                // Control flops: valid bits and last markers are cleared by
                // rst/flush; a flushed slice must not present a stale last.
                always_ff @(posedge clk) begin
                    if (rst || flush) begin
                        m_vld <= 1'b0;
                        m_lst <= 1'b0;
                        k_vld <= 1'b0;
                        k_lst <= 1'b0;
                    end else begin
                        if (main_from_skid) begin
                            // m_vld is already 1 and stays 1.
                            m_lst <= k_lst;
                            k_vld <= 1'b0;
                        end else if (main_from_in) begin
                            m_vld <= 1'b1;
                            m_lst <= in_last;
                        end else if (skid_from_in) begin
                            k_vld <= 1'b1;
                            k_lst <= in_last;
                        end else if (out_hs) begin
                            // Remaining out_hs case: no input beat and an
                            // empty skid, so the slice simply empties.
                            m_vld <= 1'b0;
                        end
                    end
                end

                // Wide data flops carry no reset: their content only matters
                // while the matching valid bit is set, which keeps reset
                // fan-out off the 512-bit datapath.
                always_ff @(posedge clk) begin
                    if (main_from_skid) begin
                        m_dat <= k_dat;
                    end else if (main_from_in) begin
                        m_dat <= in_data;
                    end
                    if (skid_from_in) begin
                        k_dat <= in_data;
                    end
                end
            end
        end
    endgenerate

`ifdef AXIS_SKID_CHAIN_OCC_EN
    localparam int OCC_W = (NUM_SLICES == 0) ? 1 : $clog2(2*NUM_SLICES + 1);

    generate
        if (NUM_SLICES == 0) begin : g_occ_none
            assign occ = '0;
        end else begin : g_occ
            logic push;
            logic pop;

            assign push = us_valid & us_ready;
            assign pop  = ds_valid & ds_ready;

            // Tracks the beats held across all slices. It can never pass
            // 2*NUM_SLICES because us_ready drops once every register is
            // full.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    occ <= '0;
                end else if (push && !pop) begin
                    occ <= occ + OCC_W'(1);
                end else if (pop && !push) begin
                    occ <= occ - OCC_W'(1);
                end
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_axis_skid_chain.sv
// -----------------------------------------------------------------------------
// tb_axis_skid_chain
//
// Directed bench for axis_skid_chain. Instances:
//   u_a : NUM_SLICES=3, DATA_W=512  (streaming, latency, capacity, drain,
//                                    mid-stream reset)
//   u_b : NUM_SLICES=2, DATA_W=32   (random traffic scoreboard, flush)
//   u_c : NUM_SLICES=0, DATA_W=8    (combinational pass-through)
//   u_d : NUM_SLICES=4, DATA_W=16   (occupancy counter; only with
//                                    AXIS_SKID_CHAIN_OCC_EN defined)
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_axis_skid_chain;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- DUT A signals ----------------
    logic         a_flush, a_us_valid, a_us_last, a_us_ready;
    logic         a_ds_valid, a_ds_last, a_ds_ready;
    logic [511:0] a_us_data, a_ds_data;

    // ---------------- DUT B signals ----------------
    logic         b_flush, b_us_valid, b_us_last, b_us_ready;
    logic         b_ds_valid, b_ds_last, b_ds_ready;
    logic [31:0]  b_us_data, b_ds_data;

    // ---------------- DUT C signals ----------------
    logic         c_flush, c_us_valid, c_us_last, c_us_ready;
    logic         c_ds_valid, c_ds_last, c_ds_ready;
    logic [7:0]   c_us_data, c_ds_data;

`ifdef AXIS_SKID_CHAIN_OCC_EN
    logic [2:0]   a_occ;
    logic [2:0]   b_occ;
    logic         c_occ;
    logic [3:0]   d_occ;
    logic         d_flush, d_us_valid, d_us_last, d_us_ready;
    logic         d_ds_valid, d_ds_last, d_ds_ready;
    logic [15:0]  d_us_data, d_ds_data;
    int           occ_exp [7] = '{8, 7, 6, 5, 4, 4, 4};
`endif

    // ---------------- instances ----------------
    axis_skid_chain #(.DATA_W(512), .NUM_SLICES(3)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .us_valid(a_us_valid), .us_data(a_us_data), .us_last(a_us_last), .us_ready(a_us_ready),
        .ds_valid(a_ds_valid), .ds_data(a_ds_data), .ds_last(a_ds_last), .ds_ready(a_ds_ready)
`ifdef AXIS_SKID_CHAIN_OCC_EN
       ,.occ(a_occ)
`endif
    );

    axis_skid_chain #(.DATA_W(32), .NUM_SLICES(2)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .us_valid(b_us_valid), .us_data(b_us_data), .us_last(b_us_last), .us_ready(b_us_ready),
        .ds_valid(b_ds_valid), .ds_data(b_ds_data), .ds_last(b_ds_last), .ds_ready(b_ds_ready)
`ifdef AXIS_SKID_CHAIN_OCC_EN
       ,.occ(b_occ)
`endif
    );

    axis_skid_chain #(.DATA_W(8), .NUM_SLICES(0)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush),
        .us_valid(c_us_valid), .us_data(c_us_data), .us_last(c_us_last), .us_ready(c_us_ready),
        .ds_valid(c_ds_valid), .ds_data(c_ds_data), .ds_last(c_ds_last), .ds_ready(c_ds_ready)
`ifdef AXIS_SKID_CHAIN_OCC_EN
       ,.occ(c_occ)
`endif
    );

`ifdef AXIS_SKID_CHAIN_OCC_EN
    axis_skid_chain #(.DATA_W(16), .NUM_SLICES(4)) u_d (
        .clk(clk), .rst(rst), .flush(d_flush),
        .us_valid(d_us_valid), .us_data(d_us_data), .us_last(d_us_last), .us_ready(d_us_ready),
        .ds_valid(d_ds_valid), .ds_data(d_ds_data), .ds_last(d_ds_last), .ds_ready(d_ds_ready),
        .occ(d_occ)
    );
`endif

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];      // {last, data} of beats accepted by u_b
    int          sent, got, acc, seen, vld_cnt;
    int          first_acc, last_acc, first_ds, last_ds;
    logic        b_acc, b_hold;
    logic [11:0] rdy_hist;

    // ---------------- check tasks ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver helper ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #950000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        a_flush = 0; a_us_valid = 0; a_us_data = '0; a_us_last = 0; a_ds_ready = 0;
        b_flush = 0; b_us_valid = 0; b_us_data = '0; b_us_last = 0; b_ds_ready = 0;
        c_flush = 0; c_us_valid = 0; c_us_data = '0; c_us_last = 0; c_ds_ready = 0;
`ifdef AXIS_SKID_CHAIN_OCC_EN
        d_flush = 0; d_us_valid = 0; d_us_data = '0; d_us_last = 0; d_ds_ready = 0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ---- reset values ----
        @(negedge clk);
        chk1("a_rst_ds_valid", a_ds_valid, 1'b0);
        chk1("a_rst_ds_last", a_ds_last, 1'b0);
        chk1("a_rst_us_ready", a_us_ready, 1'b1);
        chk1("b_rst_ds_valid", b_ds_valid, 1'b0);
        chk1("b_rst_ds_last", b_ds_last, 1'b0);
        chk1("b_rst_us_ready", b_us_ready, 1'b1);
`ifdef AXIS_SKID_CHAIN_OCC_EN
        chkn("d_rst_occ", 32'(d_occ), 32'd0);
        chk1("d_rst_us_ready", d_us_ready, 1'b1);
`endif

        // ---- test 1: 3 slices, ds_ready=1, beats 0x1..0x10 back-to-back ----
        a_ds_ready = 1'b1;
        sent = 0; got = 0;
        first_acc = -1; last_acc = -1; first_ds = -1; last_ds = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            next_cycle();
            a_us_valid = (sent < 16);
            a_us_data  = 512'(sent + 1);
            a_us_last  = (sent == 15);
            @(negedge clk);
            if (a_us_valid && a_us_ready) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            if (a_ds_valid && a_ds_ready) begin
                if (first_ds < 0) first_ds = cyc;
                last_ds = cyc;
                chkw("t1_data", a_ds_data, 512'(got + 1));
                chk1("t1_last", a_ds_last, got == 15);
                got++;
            end
        end
        chkn("t1_beats_out", 32'(got), 32'd16);
        chkn("t1_latency", 32'(first_ds - first_acc), 32'd3);
        chkn("t1_us_rate", 32'(last_acc - first_acc), 32'd15);
        chkn("t1_ds_rate", 32'(last_ds - first_ds), 32'd15);

        // ---- test 2: 3 slices, ds_ready=0, fill to capacity then drain ----
        a_ds_ready = 1'b0;
        acc = 0;
        rdy_hist = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            next_cycle();
            a_us_valid = 1'b1;
            a_us_data  = 512'(acc + 1);
            a_us_last  = 1'b0;
            @(negedge clk);
            rdy_hist[cyc] = a_us_ready;
            if (a_us_valid && a_us_ready) acc++;
        end
        chkn("t2_accepted", 32'(acc), 32'd6);
        chkn("t2_ready_hist", 32'(rdy_hist), 32'h03F);

        next_cycle();
        a_ds_ready = 1'b1;
        a_us_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 4) chk1("t2_ready_wave", a_us_ready, k == 3);
            if (k < 6) begin
                chk1("t2_drain_valid", a_ds_valid, 1'b1);
                chkw("t2_drain_data", a_ds_data, 512'(k + 1));
                chk1("t2_drain_last", a_ds_last, 1'b0);
            end else begin
                chk1("t2_drain_done", a_ds_valid, 1'b0);
            end
            next_cycle();
        end

        // ---- mid-stream reset on 3 slices ----
        a_ds_ready = 1'b0;
        a_us_valid = 1'b1;
        a_us_last  = 1'b1;
        a_us_data  = 512'h77;
        @(negedge clk);
        chk1("rst_mid_accept", a_us_ready, 1'b1);
        next_cycle();
        a_us_data = 512'h78;
        next_cycle();
        rst = 1'b1;
        a_us_data = 512'h79;
        next_cycle();
        rst = 1'b0;
        a_us_valid = 1'b0;
        a_us_last  = 1'b0;
        a_ds_ready = 1'b1;
        @(negedge clk);
        chk1("rst_mid_ds_valid", a_ds_valid, 1'b0);
        chk1("rst_mid_us_ready", a_us_ready, 1'b1);
        chk1("rst_mid_ds_last", a_ds_last, 1'b0);
        vld_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            if (a_ds_valid) vld_cnt++;
        end
        chkn("rst_mid_no_beats", 32'(vld_cnt), 32'd0);

        // ---- test 3: 2 slices, random valid/ready, 10000 beats ----
        sent = 0; got = 0;
        b_acc = 1'b0; b_hold = 1'b0;
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            next_cycle();
            if (b_acc) b_us_valid = 1'b0;
            if (!b_us_valid && sent < 10000 && $urandom_range(0, 1) == 1) begin
                b_us_valid = 1'b1;
                b_us_data  = 32'(sent);
                b_us_last  = (sent % 7 == 6);
            end
            b_ds_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (b_hold) chk1("t3_valid_held", b_ds_valid, 1'b1);
            if (b_ds_valid) begin
                chk1("t3_beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chkn("t3_data", b_ds_data, exp_q[0][31:0]);
                    chk1("t3_last", b_ds_last, exp_q[0][32]);
                    if (b_ds_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            b_hold = b_ds_valid && !b_ds_ready;
            b_acc  = b_us_valid && b_us_ready;
            if (b_acc) begin
                exp_q.push_back({b_us_last, b_us_data});
                sent++;
            end
        end
        chkn("t3_received", 32'(got), 32'd10000);
        chkn("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // ---- test 4: 2 slices, 3 beats buffered, flush with a beat offered ----
        next_cycle();
        b_us_valid = 1'b0;
        b_ds_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_us_valid = 1'b1;
            b_us_data  = 32'h11 + 32'(k);
            b_us_last  = (k == 0);
            @(negedge clk);
            chk1("t4_fill_ready", b_us_ready, 1'b1);
            next_cycle();
        end
        b_us_valid = 1'b1;
        b_us_data  = 32'hAA;
        b_us_last  = 1'b1;
        b_flush    = 1'b1;
        @(negedge clk);
        chk1("t4_pre_us_ready", b_us_ready, 1'b1);
        chk1("t4_pre_ds_valid", b_ds_valid, 1'b1);
        chkn("t4_pre_ds_data", b_ds_data, 32'h11);
        chk1("t4_pre_ds_last", b_ds_last, 1'b1);
        next_cycle();
        b_flush    = 1'b0;
        b_us_valid = 1'b0;
        b_us_last  = 1'b0;
        b_ds_ready = 1'b1;
        @(negedge clk);
        chk1("t4_post_ds_valid", b_ds_valid, 1'b0);
        chk1("t4_post_us_ready", b_us_ready, 1'b1);
        chk1("t4_post_ds_last", b_ds_last, 1'b0);
        vld_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            @(negedge clk);
            if (b_ds_valid) vld_cnt++;
        end
        chkn("t4_nothing_after_flush", 32'(vld_cnt), 32'd0);
        next_cycle();
        b_us_valid = 1'b1;
        b_us_data  = 32'h55;
        @(negedge clk);
        chk1("t4_reuse_accept", b_us_ready, 1'b1);
        next_cycle();
        b_us_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b_ds_valid && seen == 0) begin
                chkn("t4_reuse_data", b_ds_data, 32'h55);
                seen = 1;
            end
            next_cycle();
        end
        chkn("t4_reuse_seen", 32'(seen), 32'd1);

        // ---- test 5: 0 slices, pure pass-through ----
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            c_us_valid = ($urandom_range(0, 1) == 1);
            c_us_data  = 8'($urandom_range(0, 255));
            c_us_last  = ($urandom_range(0, 1) == 1);
            c_ds_ready = ($urandom_range(0, 1) == 1);
            c_flush    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk1("t5_ds_valid", c_ds_valid, c_us_valid);
            chkn("t5_ds_data", 32'(c_ds_data), 32'(c_us_data));
            chk1("t5_ds_last", c_ds_last, c_us_last);
            chk1("t5_us_ready", c_us_ready, c_ds_ready);
        end

`ifdef AXIS_SKID_CHAIN_OCC_EN
        // ---- test 6: occupancy counter on 4 slices ----
        chkn("t6_occ_zero_slices", 32'(c_occ), 32'd0);
        next_cycle();
        d_ds_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            d_us_valid = 1'b1;
            d_us_data  = 16'(k + 1);
            @(negedge clk);
            chk1("t6_fill_ready", d_us_ready, 1'b1);
            chkn("t6_occ_step", 32'(d_occ), 32'(k));
            next_cycle();
        end
        d_us_data = 16'd9;
        @(negedge clk);
        chkn("t6_occ_full", 32'(d_occ), 32'd8);
        chk1("t6_full_ready", d_us_ready, 1'b0);
        next_cycle();
        d_ds_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chkn("t6_occ_drain", 32'(d_occ), 32'(occ_exp[k]));
            chk1("t6_ready_wave", d_us_ready, k >= 4);
            if (d_us_valid && d_us_ready) acc++;
            next_cycle();
            d_us_data = 16'(9 + acc);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        d_us_valid = 1'b0;
        @(negedge clk);
        chkn("t6_occ_rst", 32'(d_occ), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
